// File: rtl/game_scoreboard_pkg.sv
// Shared state type and default parameters for the game scoreboard slice.
// Pure declarations: no logic, no latency.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int DEF_NUM_PLAYERS  = 2;
  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_FLASH_CYCLES = 100;

endpackage

// File: rtl/game_scoreboard_if.sv
// Control/status bundle between the game controller (master) and the scoreboard (slave).
// Wires only: no latency, no backpressure.
interface game_scoreboard_if
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W
);
  logic                           clear;
  logic                           serve;
  logic [NUM_PLAYERS-1:0]         point;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic                           playing;
  logic                           flash;
  logic                           game_over;
  logic [NUM_PLAYERS-1:0]         winner;
  logic                           point_err;

  modport master (
    output clear, serve, point,
    input  score, playing, flash, game_over, winner, point_err
  );

  modport slave (
    input  clear, serve, point,
    output score, playing, flash, game_over, winner, point_err
  );
endinterface

// File: rtl/game_scoreboard_flash_timer.sv
// Post-point flash timer: start loads FLASH_CYCLES, done is high during the last counted clock.
// Combinational done from a registered count; clear and start are sampled every clock, no backpressure.
module flash_timer
  import game_pkg::*;
#(
  parameter int FLASH_CYCLES = DEF_FLASH_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic start,
  output logic done
);
  localparam int CNT_W = $clog2(FLASH_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(FLASH_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Count N is loaded on the edge entering FLASH, so done at 1 makes FLASH exactly N clocks long.
  assign done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/game_scoreboard.sv
// Game scoreboard FSM with saturating scores and win detect; SCOREBOARD_WIN_BY_TWO_EN selects the win-by-two rule.
// All outputs registered (one-clock response, game_over on the winning edge); serve/point sampled every clock, no backpressure.
module game_scoreboard
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int FLASH_CYCLES = DEF_FLASH_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  game_scoreboard_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PLAYERS);
  localparam logic [SCORE_W-1:0] MAX_SCORE = '1;
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

  state_t                         r_state;
  logic [SCORE_W-1:0]             r_score [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]         r_winner;
  logic                           r_playing;
  logic                           r_flash;
  logic                           r_game_over;
  logic                           r_point_err;

  logic                           w_single;
  logic                           w_multi;
  logic                           w_win;
  logic                           w_done;
  logic                           w_start;
  logic [IDX_W-1:0]               w_idx;
  logic [SCORE_W-1:0]             w_new;
  logic [NUM_PLAYERS*SCORE_W-1:0] w_score;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.point[i]) w_idx = IDX_W'(i);
    end
    w_single = $onehot(bus.point);
    w_multi  = (bus.point != '0) && !w_single;
    w_new    = (r_score[w_idx] == MAX_SCORE) ? r_score[w_idx] : r_score[w_idx] + SCORE_W'(1);
  end

`ifdef SCOREBOARD_WIN_BY_TWO_EN
  localparam logic [SCORE_W:0] TWO = (SCORE_W+1)'(2);
  logic w_lead2;
  logic w_lead1;

  // Other players' scores are unchanged on a point edge, so compare against the registered values.
  always_comb begin
    w_lead2 = 1'b1;
    w_lead1 = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (IDX_W'(i) != w_idx) begin
        if ({1'b0, w_new} < ({1'b0, r_score[i]} + TWO)) w_lead2 = 1'b0;
        if (w_new <= r_score[i]) w_lead1 = 1'b0;
      end
    end
    w_win = ((w_new >= WIN_S) && w_lead2) || ((w_new == MAX_SCORE) && w_lead1);
  end
`else
  assign w_win = (w_new == WIN_S);
`endif

  assign w_start = (r_state == PLAY) && w_single && !w_win && !bus.clear;

  flash_timer #(
    .FLASH_CYCLES (FLASH_CYCLES)
  ) u_flash_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.clear),
    .start   (w_start),
    .done    (w_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_winner    <= '0;
      r_playing   <= 1'b0;
      r_flash     <= 1'b0;
      r_game_over <= 1'b0;
      r_point_err <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_point_err <= 1'b0;
      if (bus.clear) begin
        r_state     <= IDLE;
        r_winner    <= '0;
        r_playing   <= 1'b0;
        r_flash     <= 1'b0;
        r_game_over <= 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.serve) begin
              r_state   <= PLAY;
              r_playing <= 1'b1;
            end
          end
          PLAY: begin
            if (w_single) begin
              r_score[w_idx] <= w_new;
              r_playing      <= 1'b0;
              if (w_win) begin
                r_state     <= OVER;
                r_game_over <= 1'b1;
                r_winner    <= bus.point;
              end else begin
                r_state <= FLASH;
                r_flash <= 1'b1;
              end
            end else if (w_multi) begin
              r_point_err <= 1'b1;
            end
          end
          FLASH: begin
            if (w_done) begin
              r_state <= IDLE;
              r_flash <= 1'b0;
            end
          end
          OVER: begin
          end
          default: begin
            r_state     <= IDLE;
            r_playing   <= 1'b0;
            r_flash     <= 1'b0;
            r_game_over <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) w_score[i*SCORE_W +: SCORE_W] = r_score[i];
  end

  assign bus.score     = w_score;
  assign bus.playing   = r_playing;
  assign bus.flash     = r_flash;
  assign bus.game_over = r_game_over;
  assign bus.winner    = r_winner;
  assign bus.point_err = r_point_err;

endmodule

// File: tb/tb_game_scoreboard.sv
// Bench for game_scoreboard: rule-level model compared every cycle, plus directed literal checks.
module tb_game_scoreboard;
  localparam int NP   = 2;
  localparam int SW   = 4;
  localparam int WIN  = 9;
  localparam int FC   = 100;
  localparam int MAXS = 15;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  game_scoreboard_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) bus ();

  game_scoreboard #(
    .NUM_PLAYERS  (NP),
    .SCORE_W      (SW),
    .WIN_SCORE    (WIN),
    .FLASH_CYCLES (FC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Model: scores as integers, phase as independent flags plus a flash countdown.
  int          m_score [NP];
  bit          m_play;
  bit          m_over;
  bit          m_perr;
  int          m_flash_left;
  logic [NP-1:0] m_winner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    m_play = 0; m_over = 0; m_perr = 0; m_flash_left = 0; m_winner = '0;
  endfunction

  function automatic bit model_wins(input int p);
    int s;
    s = m_score[p];
`ifdef SCOREBOARD_WIN_BY_TWO_EN
    begin
      bit ok2, ok1;
      ok2 = 1; ok1 = 1;
      for (int i = 0; i < NP; i++) begin
        if (i != p) begin
          if (s - m_score[i] < 2) ok2 = 0;
          if (s <= m_score[i]) ok1 = 0;
        end
      end
      return (s >= WIN && ok2) || (s == MAXS && ok1);
    end
`else
    return s == WIN;
`endif
  endfunction

  function automatic void model_step();
    int n, p;
    m_perr = 0;
    if (bus.clear) begin
      model_reset();
    end else if (m_over) begin
    end else if (m_flash_left > 0) begin
      m_flash_left--;
    end else if (m_play) begin
      n = $countones(bus.point);
      p = 0;
      for (int i = 0; i < NP; i++) if (bus.point[i]) p = i;
      if (n == 1) begin
        if (m_score[p] < MAXS) m_score[p]++;
        m_play = 0;
        if (model_wins(p)) begin
          m_over   = 1;
          m_winner = NP'(1) << p;
        end else begin
          m_flash_left = FC;
        end
      end else if (n > 1) begin
        m_perr = 1;
      end
    end else if (bus.serve) begin
      m_play = 1;
    end
  endfunction

  always @(posedge clock) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    logic [NP*SW-1:0] e;
    e = '0;
    for (int i = 0; i < NP; i++) e[i*SW +: SW] = SW'(m_score[i]);
    chk("cmp_score",     32'(bus.score),     32'(e));
    chk("cmp_playing",   32'(bus.playing),   32'(m_play));
    chk("cmp_flash",     32'(bus.flash),     32'(m_flash_left > 0));
    chk("cmp_game_over", 32'(bus.game_over), 32'(m_over));
    chk("cmp_winner",    32'(bus.winner),    32'(m_winner));
    chk("cmp_point_err", 32'(bus.point_err), 32'(m_perr));
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.flash === 1'b1 && k < FC + 20) begin
      @(negedge clock);
      k++;
    end
    chk("flash_timeout", 32'(bus.flash), 0);
  endtask

  task automatic rally(input logic [NP-1:0] pm);
    bus.serve = 1'b1;
    @(negedge clock);
    bus.serve = 1'b0;
    bus.point = pm;
    @(negedge clock);
    bus.point = '0;
    wait_idle();
  endtask

  initial begin
    int n;
    bus.clear = 1'b0; bus.serve = 1'b0; bus.point = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_score",     32'(bus.score), 0);
    chk("rst_status",    32'({bus.playing, bus.flash, bus.game_over}), 0);
    chk("rst_winner",    32'(bus.winner), 0);
    chk("rst_point_err", 32'(bus.point_err), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // point in IDLE is ignored
    bus.point = 2'b10;
    @(negedge clock);
    bus.point = '0;
    chk("idle_ignore_score", 32'(bus.score), 0);
    chk("idle_ignore_err",   32'(bus.point_err), 0);

    // basic rally: score0=1 then exactly FC flash clocks, serve ignored mid-flash
    bus.serve = 1'b1;
    @(negedge clock);
    bus.serve = 1'b0;
    chk("serve_play", 32'(bus.playing), 1);
    bus.point = 2'b01;
    @(negedge clock);
    bus.point = '0;
    chk("rally_score", 32'(bus.score), 32'h01);
    chk("rally_flash", 32'(bus.flash), 1);
    n = 0;
    while (bus.flash === 1'b1 && n < 2 * FC) begin
      n++;
      bus.serve = (n == 50);
      @(negedge clock);
    end
    bus.serve = 1'b0;
    chk("flash_len", 32'(n), 100);
    chk("post_flash_idle", 32'({bus.playing, bus.flash}), 0);

    // illegal point vector
    bus.serve = 1'b1;
    @(negedge clock);
    bus.serve = 1'b0;
    bus.point = 2'b11;
    @(negedge clock);
    bus.point = '0;
    chk("illegal_err",   32'(bus.point_err), 1);
    chk("illegal_play",  32'(bus.playing), 1);
    chk("illegal_score", 32'(bus.score), 32'h01);
    @(negedge clock);
    chk("illegal_err_pulse", 32'(bus.point_err), 0);

    // clear beats serve and point
    bus.clear = 1'b1; bus.serve = 1'b1; bus.point = 2'b01;
    @(negedge clock);
    bus.clear = 1'b0; bus.serve = 1'b0; bus.point = '0;
    chk("clear_state", 32'({bus.playing, bus.flash, bus.game_over}), 0);
    chk("clear_score", 32'(bus.score), 0);

    // player1 to nine points wins
    for (int r = 0; r < 9; r++) rally(2'b10);
    chk("win_over",   32'(bus.game_over), 1);
    chk("win_winner", 32'(bus.winner), 32'b10);
    chk("win_score",  32'(bus.score), 32'h90);
    bus.serve = 1'b1; bus.point = 2'b10;
    repeat (3) @(negedge clock);
    bus.serve = 1'b0; bus.point = 2'b11;
    @(negedge clock);
    bus.point = '0;
    @(negedge clock);
    chk("over_hold_score", 32'(bus.score), 32'h90);
    chk("over_hold_flag",  32'({bus.game_over, bus.flash, bus.point_err}), 32'b100);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    chk("over_clear", 32'({bus.game_over, bus.winner, bus.score}), 0);

`ifdef SCOREBOARD_WIN_BY_TWO_EN
    for (int r = 0; r < 9; r++) begin
      rally(2'b01);
      rally(2'b10);
    end
    chk("wb2_9_9", 32'({bus.game_over, bus.score}), 32'h099);
    rally(2'b01);
    chk("wb2_10_9", 32'({bus.game_over, bus.score}), 32'h09A);
    rally(2'b01);
    chk("wb2_11_9", 32'({bus.game_over, bus.score}), 32'h19B);
    chk("wb2_winner", 32'(bus.winner), 32'b01);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
`endif

    // async reset mid-flash
    bus.serve = 1'b1;
    @(negedge clock);
    bus.serve = 1'b0;
    bus.point = 2'b01;
    @(negedge clock);
    bus.point = '0;
    repeat (10) @(negedge clock);
    chk("pre_rst_flash", 32'(bus.flash), 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out", 32'({bus.flash, bus.playing, bus.game_over, bus.point_err}), 0);
    chk("async_rst_score", 32'(bus.score), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_idle", 32'({bus.playing, bus.flash, bus.point_err}), 0);
    bus.serve = 1'b1;
    @(negedge clock);
    bus.serve = 1'b0;
    chk("post_rst_serve", 32'(bus.playing), 1);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 The block SHALL take parameter NUM_PLAYERS, default 2, the number of independent score channels (legal range 2..4).
REQ-002 The block SHALL take parameter SCORE_W, default 4, the width of each score counter.
REQ-003 The block SHALL take parameter WIN_SCORE, default 9, the score that ends the game (must be below 2**SCORE_W).
REQ-004 The block SHALL take parameter FLASH_CYCLES, default 100, the length of the post-point flash state in clocks (>=1).
REQ-005 Port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port clear  input  1  synchronous new-game request, already synchronized.
REQ-008 Port serve  input  1  serve request, level sampled each clock.
REQ-009 Port point  input  NUM_PLAYERS  bit i high for one clock means player i scored.
REQ-010 Port score  output  NUM_PLAYERS*SCORE_W  packed scores; player i at bits [i*SCORE_W +: SCORE_W].
REQ-011 Port playing  output  1  high in PLAY.
REQ-012 Port flash  output  1  high in FLASH.
REQ-013 Port game_over  output  1  high in OVER.
REQ-014 Port winner  output  NUM_PLAYERS  one-hot winning player, valid while game_over.
REQ-015 Port point_err  output  1  one-clock pulse on an illegal point vector in PLAY.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, FLASH and OVER.
REQ-017 IDLE SHALL go to PLAY on the clock where serve=1.
REQ-018 In PLAY, a point vector with exactly one bit set SHALL increment that player's score on the next edge.
REQ-019 On that same edge the FSM SHALL go to FLASH, or to OVER if the updated score meets the win rule.
REQ-020 In PLAY, a point vector with more than one bit set SHALL leave scores and state unchanged and pulse point_err for one clock.
REQ-021 point SHALL be ignored in IDLE, FLASH and OVER, with no score change and no point_err.
REQ-022 FLASH SHALL last exactly FLASH_CYCLES clocks, then go to IDLE; serve is ignored during FLASH.
REQ-023 OVER SHALL hold the scores and winner until clear.
REQ-024 clear SHALL override all other inputs: next state IDLE, all scores 0, winner 0, flash timer 0.
REQ-025 Each score SHALL saturate at 2**SCORE_W-1 and never wrap.
REQ-026 A point to a saturated player SHALL still enter FLASH, with the score unchanged.
REQ-027 game_over and winner SHALL assert on the same edge that writes the winning score (zero extra latency).
REQ-028 playing, flash and game_over SHALL be registered decodes of the state, never more than one high at a time.

Reset
REQ-029 On reset_n=0 the block SHALL immediately force state IDLE, all scores 0, winner 0, point_err 0, flash timer 0 and all status outputs 0.
REQ-030 Reset asserted mid-FLASH or in OVER SHALL abandon that state with no residual pulse after release.

Configuration
REQ-031 With SCOREBOARD_WIN_BY_TWO_EN undefined, a player SHALL win when their score equals WIN_SCORE.
REQ-032 With SCOREBOARD_WIN_BY_TWO_EN defined, a player SHALL win when their score is >= WIN_SCORE and at least 2 above every other player.
REQ-033 With SCOREBOARD_WIN_BY_TWO_EN defined, a player SHALL also win on reaching saturation while strictly leading all others.

Structure
REQ-034 Package game_pkg SHALL hold the state enum type and the default parameter constants.
REQ-035 The flash timer SHALL be a sub-module flash_timer (start, done, count width $clog2(FLASH_CYCLES+1)).
REQ-036 The win-rule evaluation SHALL be combinational inside game_scoreboard.

Verification
REQ-037 Bench SHALL cover a basic rally: reset, serve, point=01 -> score0=1 next clock, flash high for exactly 100 clocks, then IDLE.
REQ-038 Bench SHALL cover a win: drive player1 to 9 points -> game_over=1 and winner=10 on the 9th update edge; later points are ignored.
REQ-039 Bench SHALL cover an illegal point: point=11 in PLAY -> point_err one clock, scores unchanged, state PLAY.
REQ-040 Bench SHALL cover clear priority: clear=1 while serve=1 and point=01 in PLAY -> IDLE, scores 0.
REQ-041 Bench SHALL cover win-by-two (macro defined): at 9-9 a point gives 10-9 with no game_over; the next point gives 11-9 with game_over and winner=01.
REQ-042 Bench SHALL cover async reset: reset_n low mid-FLASH -> outputs 0 without waiting for a clock edge; after release the block stays in IDLE until serve.
